// File: rtl/lcd_595_capture_if.sv
// Serial display bus as emitted by a 74HC595 driver: data, shift clock, latch clock.
// The master drives all three lines; the capture block only observes them.
interface lcd_595_capture_if;
  logic DIO;
  logic SCLK;
  logic RCLK;

  modport master (output DIO, output SCLK, output RCLK);
  modport slave  (input  DIO, input  SCLK, input  RCLK);
endinterface

// File: rtl/lcd_595_capture.sv
// Rebuilds 74HC595 frames (segment byte + select byte) and decodes them into digit registers.
// Latency SYNC_STAGES+2 sys_clk from raw RCLK rise to a pulse; passive observer, applies no backpressure.
module lcd_595_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 4096
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  lcd_595_capture_if.slave    bus,
  output logic [7:0]          Num1,
  output logic [7:0]          Num2,
  output logic [7:0]          Num3,
  output logic [7:0]          Num4,
  output logic [3:0]          dp,
  output logic                frame_valid,
  output logic                frame_err,
  output logic [1:0]          err_code
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] dio_sync_q, sclk_sync_q, rclk_sync_q;
  logic                   sclk_prev_q, rclk_prev_q;
  logic [15:0]            sr_q, sr_d;
  logic [4:0]             bcnt_q, bcnt_d;
  logic [TW-1:0]          to_cnt_q;
  logic [7:0]             num_q [4];
  logic [3:0]             dp_q;
  logic                   frame_valid_q, frame_err_q;
  logic [1:0]             err_code_q;

  logic                   dio_s, sclk_rise, rclk_rise;
  logic                   sel_ok;
  logic [1:0]             sel_idx;

  function automatic logic [7:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h40:   return 8'd0;
      7'h79:   return 8'd1;
      7'h24:   return 8'd2;
      7'h30:   return 8'd3;
      7'h19:   return 8'd4;
      7'h12:   return 8'd5;
      7'h02:   return 8'd6;
      7'h78:   return 8'd7;
      7'h00:   return 8'd8;
      7'h10:   return 8'd9;
      7'h46:   return 8'd10;
      default: return 8'hFF;
    endcase
  endfunction

  assign dio_s     = dio_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign rclk_rise = rclk_sync_q[SYNC_STAGES-1] & ~rclk_prev_q;

  // A coincident SCLK rise is folded in before any latch decision.
  always_comb begin
    sr_d   = sr_q;
    bcnt_d = bcnt_q;
    if (sclk_rise) begin
      sr_d = {sr_q[14:0], dio_s};
      if (bcnt_q != 5'd17) bcnt_d = bcnt_q + 5'd1;
    end
  end

  always_comb begin
    sel_ok  = 1'b1;
    sel_idx = 2'd0;
    case (sr_q[7:0])
      8'h01:   sel_idx = 2'd0;
      8'h02:   sel_idx = 2'd1;
      8'h04:   sel_idx = 2'd2;
      8'h08:   sel_idx = 2'd3;
      default: sel_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      dio_sync_q    <= '0;
      sclk_sync_q   <= '0;
      rclk_sync_q   <= '0;
      sclk_prev_q   <= 1'b0;
      rclk_prev_q   <= 1'b0;
      sr_q          <= '0;
      bcnt_q        <= '0;
      to_cnt_q      <= '0;
      for (int i = 0; i < 4; i++) num_q[i] <= 8'hFF;
      dp_q          <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= '0;
    end else begin
      dio_sync_q    <= {dio_sync_q[SYNC_STAGES-2:0], bus.DIO};
      sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], bus.SCLK};
      rclk_sync_q   <= {rclk_sync_q[SYNC_STAGES-2:0], bus.RCLK};
      sclk_prev_q   <= sclk_sync_q[SYNC_STAGES-1];
      rclk_prev_q   <= rclk_sync_q[SYNC_STAGES-1];
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= '0;

      case (state_q)
        IDLE: begin
          if (rclk_rise) begin
            frame_err_q <= 1'b1;
            err_code_q  <= 2'd1;
          end else if (sclk_rise) begin
            sr_q     <= sr_d;
            bcnt_q   <= bcnt_d;
            to_cnt_q <= '0;
            state_q  <= SHIFT;
          end
        end

        SHIFT: begin
          sr_q   <= sr_d;
          bcnt_q <= bcnt_d;
          if (rclk_rise) begin
            state_q <= LATCH;
          end else if (sclk_rise) begin
            to_cnt_q <= '0;
          end else if (to_cnt_q == TW'(TIMEOUT)) begin
            frame_err_q <= 1'b1;
            err_code_q  <= 2'd3;
            bcnt_q      <= '0;
            to_cnt_q    <= '0;
            state_q     <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end

        LATCH: begin
          if (bcnt_q != 5'd16) begin
            frame_err_q <= 1'b1;
            err_code_q  <= 2'd1;
          end else if (!sel_ok) begin
            frame_err_q <= 1'b1;
            err_code_q  <= 2'd2;
          end else begin
            num_q[sel_idx] <= seg_decode(sr_q[14:8]);
            dp_q[sel_idx]  <= ~sr_q[15];
            frame_valid_q  <= 1'b1;
          end
          // A shift clock arriving during the latch cycle starts the next frame.
          sr_q     <= sr_d;
          bcnt_q   <= sclk_rise ? 5'd1 : 5'd0;
          to_cnt_q <= '0;
          state_q  <= sclk_rise ? SHIFT : IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign Num1        = num_q[0];
  assign Num2        = num_q[1];
  assign Num3        = num_q[2];
  assign Num4        = num_q[3];
  assign dp          = dp_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_lcd_595_capture.sv
// Directed frames on the serial display bus, checked against a frame-level reference model.
// Expected pulses are queued at each RCLK and matched as the DUT produces them.
module tb_lcd_595_capture;

  localparam int SYNC    = 2;
  localparam int TIMEOUT = 4096;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] Num1, Num2, Num3, Num4;
  logic [3:0] dp;
  logic       frame_valid, frame_err;
  logic [1:0] err_code;

  always #5 sys_clk = ~sys_clk;

  lcd_595_capture_if bus ();

  lcd_595_capture #(.SYNC_STAGES(SYNC), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .bus         (bus),
    .Num1        (Num1),
    .Num2        (Num2),
    .Num3        (Num3),
    .Num4        (Num4),
    .dp          (dp),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .err_code    (err_code)
  );

  typedef struct {
    bit         is_err;
    logic [1:0] code;
    int         idx;
    logic [7:0] val;
    bit         dpv;
    bit         chk_lat;
    int         t0;
  } ev_t;

  ev_t        exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  int         vcnt  = 0;
  int         ecnt  = 0;
  logic [15:0] mdl_sr  = '0;
  int          mdl_cnt = 0;
  logic [7:0]  cur_num [4];
  logic [3:0]  cur_dp;
  logic [6:0]  pats [11] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                             7'h02, 7'h78, 7'h00, 7'h10, 7'h46};

  always @(posedge sys_clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 20) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [7:0] mdl_decode(input logic [6:0] s);
    for (int i = 0; i < 11; i++)
      if (pats[i] == s) return 8'(i);
    return 8'hFF;
  endfunction

  task automatic send_bit(input logic b);
    bus.DIO = b;
    cyc_wait(3);
    bus.SCLK = 1'b1;
    mdl_sr = {mdl_sr[14:0], b};
    if (mdl_cnt < 17) mdl_cnt++;
    cyc_wait(4);
    bus.SCLK = 1'b0;
    cyc_wait(3);
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[15-i]);
  endtask

  task automatic latch();
    ev_t e;
    int  k;
    bus.RCLK  = 1'b1;
    e.t0      = cyc;
    e.chk_lat = 1'b1;
    e.idx     = 0;
    e.val     = 8'h00;
    e.dpv     = 1'b0;
    e.code    = 2'd0;
    k = -1;
    for (int i = 0; i < 4; i++) if (mdl_sr[7:0] == 8'(1 << i)) k = i;
    if (mdl_cnt != 16) begin
      e.is_err = 1'b1; e.code = 2'd1;
    end else if (k < 0) begin
      e.is_err = 1'b1; e.code = 2'd2;
    end else begin
      e.is_err = 1'b0;
      e.idx    = k;
      e.val    = mdl_decode(mdl_sr[14:8]);
      e.dpv    = ~mdl_sr[15];
    end
    exp_q.push_back(e);
    mdl_cnt = 0;
    cyc_wait(4);
    bus.RCLK = 1'b0;
    cyc_wait(8);
  endtask

  task automatic frame(input logic [7:0] seg, input logic [7:0] sel);
    send_bits({seg, sel}, 16);
    latch();
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    mdl_sr  = '0;
    mdl_cnt = 0;
    cyc_wait(3);
    sys_rst = 1'b0;
    cyc_wait(2);
  endtask

  always @(negedge sys_clk) begin
    ev_t e;
    if (sys_rst) begin
      for (int i = 0; i < 4; i++) cur_num[i] = 8'hFF;
      cur_dp = 4'h0;
      exp_q.delete();
    end else begin
      if (frame_valid) vcnt++;
      if (frame_err) ecnt++;
      if (frame_valid && frame_err) chk("valid_and_err_exclusive", 64'd1, 64'd0);
      if (frame_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {frame_valid, frame_err}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", {frame_valid, frame_err}, {~e.is_err, e.is_err});
          if (e.is_err) chk("err_code", err_code, e.code);
          if (e.chk_lat) chk("rclk_to_pulse_latency", cyc - e.t0, SYNC + 2);
          if (!e.is_err) begin
            cur_num[e.idx] = e.val;
            cur_dp[e.idx]  = e.dpv;
          end
        end
      end
      chk("digit_regs", {Num1, Num2, Num3, Num4, dp},
          {cur_num[0], cur_num[1], cur_num[2], cur_num[3], cur_dp});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bus.DIO  = 1'b0;
    bus.SCLK = 1'b0;
    bus.RCLK = 1'b0;
    sys_rst  = 1'b1;
    cyc_wait(4);
    chk("rst_nums", {Num1, Num2, Num3, Num4}, 32'hFFFF_FFFF);
    chk("rst_dp_pulses", {dp, frame_valid, frame_err, err_code}, 8'h00);
    sys_rst = 1'b0;
    cyc_wait(2);

    frame(8'hC0, 8'h01);
    chk("first_frame_num1", Num1, 8'h00);
    chk("first_frame_others", {Num2, Num3, Num4, dp}, 28'hFFF_FFF0);
    chk("first_frame_vcnt", vcnt, 1);

    frame(8'hF9, 8'h01);
    frame(8'hA4, 8'h02);
    frame(8'h30, 8'h04);
    frame(8'hC6, 8'h08);
    chk("four_frames_nums", {Num1, Num2, Num3, Num4}, 32'h0102_030A);
    chk("four_frames_dp", dp, 4'b0100);
    chk("four_frames_vcnt", vcnt, 5);

    send_bits(16'hC001, 15);
    latch();
    chk("short_frame_err", ecnt, 1);
    chk("short_frame_nums", {Num1, Num2, Num3, Num4}, 32'h0102_030A);
    frame(8'h99, 8'h01);
    chk("after_short_num1", Num1, 8'h04);

    frame(8'hA4, 8'h03);
    frame(8'hA4, 8'h00);
    chk("bad_sel_errs", ecnt, 3);
    chk("bad_sel_nums", {Num1, Num2, Num3, Num4}, 32'h0402_030A);
    frame(8'hFF, 8'h02);
    chk("blank_seg_num2", Num2, 8'hFF);
    chk("blank_seg_dp", dp, 4'b0100);
    chk("blank_seg_vcnt", vcnt, 7);

    send_bits(16'h8204, 8);
    begin
      ev_t e;
      e.is_err = 1'b1; e.code = 2'd3; e.idx = 0; e.val = 8'h00;
      e.dpv = 1'b0; e.chk_lat = 1'b0; e.t0 = 0;
      exp_q.push_back(e);
      mdl_cnt = 0;
    end
    cyc_wait(TIMEOUT + 300);
    chk("timeout_err", ecnt, 4);
    frame(8'h82, 8'h04);
    chk("after_timeout_num3", Num3, 8'h06);
    chk("after_timeout_dp", dp, 4'b0000);

    send_bits(16'hF808, 10);
    do_reset();
    chk("midframe_reset_nums", {Num1, Num2, Num3, Num4}, 32'hFFFF_FFFF);
    frame(8'hF8, 8'h08);
    chk("after_reset_num4", {Num1, Num2, Num3, Num4}, 32'hFFFF_FF07);

    cyc_wait(20);
    chk("queue_drained", exp_q.size(), 0);
    chk("total_valid", vcnt, 9);
    chk("total_err", ecnt, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_595_capture.md
Name: lcd_595_capture

Overview:
- Receive-side counterpart of the 74HC595 seven-segment display driver.
- Monitors the serial DIO/SCLK/RCLK bus the driver emits and rebuilds each frame: one segment byte followed by one digit-select byte, committed by RCLK.
- Decodes the segment byte back to a digit index and updates the matching digit register (Num1..Num4).
- Used for on-chip loopback/self-check of the display path and as the bench checker for the driver.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on DIO, SCLK and RCLK (minimum 2).
- TIMEOUT, 4096: sys_clk cycles with no SCLK/RCLK rising edge, while mid-frame, before the partial frame is discarded.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous, active-high reset.
- DIO  in  1  serial data, asynchronous to sys_clk.
- SCLK  in  1  shift clock, asynchronous; data is captured on its rising edge.
- RCLK  in  1  latch clock, asynchronous; the frame is committed on its rising edge.
- Num1  out  8  digit 1 decoded index.
- Num2  out  8  digit 2 decoded index.
- Num3  out  8  digit 3 decoded index.
- Num4  out  8  digit 4 decoded index.
- dp  out  4  decimal point lit, per digit (bit0 = digit 1).
- frame_valid  out  1  one-cycle pulse: a digit register was updated.
- frame_err  out  1  one-cycle pulse: frame discarded.
- err_code  out  2  reason, valid while frame_err=1.

Behaviour:
- Reset values (sys_rst=1 at a sys_clk edge): Num1..Num4=8'hFF, dp=0, frame_valid=0, frame_err=0, err_code=0, shift register=0, bit count=0, state=IDLE, synchronizer flops=0.
- Reset mid-frame drops the partial frame with no error pulse.
- Input conditioning:
  - Each input passes through SYNC_STAGES flops.
  - A rising edge is detected as synced=1 with the previous value 0.
  - DIO is sampled from its synced copy on the same cycle the SCLK edge is detected, so DIO must be stable for SYNC_STAGES+1 sys_clk around the SCLK rise.
- Shift: each SCLK rise does sr <= {sr[14:0], DIO} (MSB first) and bit count +1, saturating at 17.
- Frame layout at RCLK: sr[15:8] = segment byte, sr[7:0] = select byte.
- States:
  - IDLE: first SCLK rise -> SHIFT. RCLK rise in IDLE -> error, code 1, then stay IDLE.
  - SHIFT: shifts on each SCLK rise. RCLK rise -> LATCH. If the timeout counter reaches TIMEOUT -> error, code 3, clear bit count, go to IDLE. The timeout counter clears on every SCLK rise.
  - LATCH: lasts one cycle. Clear bit count, return to IDLE. Outputs are registered one cycle after LATCH, so latency is SYNC_STAGES+2 sys_clk from the raw RCLK rise to frame_valid/frame_err.
- LATCH checks, in priority order:
  - Bit count != 16 -> err_code=1 (length error).
  - Select byte not exactly one of 01/02/04/08 -> err_code=2.
  - Otherwise the digit selected by the byte (01->Num1, 02->Num2, 04->Num3, 08->Num4) is updated and frame_valid pulses.
- Decode (active-low segments):
  - Match on seg[6:0]: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 46->10 ('C').
  - Any other pattern -> 8'hFF. This is still a valid frame: frame_valid pulses and no error is raised.
  - dp[digit] = ~seg[7].
- Error pulses:
  - On any error, frame_err pulses and no Num/dp output changes.
  - frame_valid and frame_err are never both high.
- Simultaneous SCLK and RCLK rises on the same cycle: the shift is applied first and the latch sees the updated sr and count.

Test Plan:
- Reset, then a frame with seg=C0, sel=01, RCLK -> Num1=0, dp[0]=0, one frame_valid pulse; Num2..Num4 stay FF.
- Four frames (F9/01, A4/02, 30/04 i.e. 3 with DP lit, C6/08) -> Num1=1, Num2=2, Num3=3, dp[2]=1, Num4=10, four frame_valid pulses.
- Only 15 bits shifted, then RCLK -> frame_err, err_code=1; outputs unchanged. A following good 16-bit frame is accepted.
- sel=03 or sel=00 -> frame_err, err_code=2, no digit update. seg=FF with sel=02 -> Num2=FF, frame_valid.
- 8 bits, then an idle gap longer than TIMEOUT -> frame_err, err_code=3. The next 16-bit frame plus RCLK decodes correctly.
- sys_rst asserted after bit 10 of a frame, then released; a fresh full frame follows -> correct decode, no spurious error pulses.
